cmd_frame_assembler: RTL and testbench
======================================

Name: cmd_frame_assembler

Overview:
- Sits between the UART byte receiver and the key/value BRAM command stage.
- Consumes the received byte stream (byte + one-cycle strobe) and assembles complete command frames: opcode, 32-bit key, and an optional 32-bit value.
- Presents each frame as one transaction on a valid/ready interface.
- Replaces ad-hoc per-command byte gating with a single framed, timed-out, back-pressured parser.

Parameters:
- TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between bytes of one frame before the partial frame is aborted.
- CNT_W, 17, width of the inter-byte timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- byte_in  in  8  received byte; sampled only when byte_valid=1.
- byte_valid  in  1  one-cycle strobe per received byte.
- cmd_valid  out  1  frame available; held until accepted.
- cmd_ready  in  1  downstream accepts the frame when cmd_valid&cmd_ready.
- cmd_op  out  2  opcode: 0=create, 1=issue, 2=transfer, 3=refer.
- cmd_key  out  32  key, first key byte in bits 31:24 (MSB first).
- cmd_value  out  32  value, MSB first; 0 for refer.
- err_opcode  out  1  one-cycle pulse: opcode byte > 3 rejected.
- err_timeout  out  1  one-cycle pulse: partial frame aborted by timeout.
- err_drop  out  1  one-cycle pulse: byte arrived while in OUT state and was discarded.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - All outputs go to 0: cmd_valid, cmd_op, cmd_key, cmd_value, err_*.
  - byte_cnt and timer are cleared.
  - Reset has priority over every other event, including mid-frame and while cmd_valid=1; a pending frame is lost.
- Frame format, byte order MSB first:
  - opcode 0, 1, 2: 1 opcode byte + 4 key bytes + 4 value bytes = 9 bytes.
  - opcode 3: 1 opcode byte + 4 key bytes = 5 bytes.
- State IDLE:
  - On byte_valid with byte_in<=3: latch cmd_op=byte_in[1:0], clear the key/value shift registers, byte_cnt=0, go to KEY.
  - On byte_valid with byte_in>3: pulse err_opcode, stay in IDLE.
  - The timer does not run in IDLE.
- State KEY:
  - Each byte_valid: key <= {key[23:0], byte_in}; byte_cnt++.
  - On the 4th key byte:
    - op==3: value=0, go to OUT.
    - otherwise: byte_cnt=0, go to VALUE.
- State VALUE:
  - Each byte_valid: value <= {value[23:0], byte_in}.
  - On the 4th value byte: go to OUT.
- State OUT:
  - cmd_valid=1, and cmd_op, cmd_key, cmd_value are stable.
  - On cmd_valid&cmd_ready: cmd_valid goes to 0 on the next edge, state goes to IDLE.
  - Latency: cmd_valid asserts on the edge after the last byte's strobe cycle.
  - A byte_valid while in OUT: discard the byte and pulse err_drop, including in the same cycle as acceptance.
  - The first byte accepted after acceptance is the one arriving in the cycle after cmd_valid drops.
- Timeout:
  - In KEY and VALUE, the timer clears on every byte_valid and increments otherwise.
  - When timer reaches TIMEOUT_CYCLES with no byte_valid that cycle: pulse err_timeout, go to IDLE, clear byte_cnt.
  - If byte_valid and the timeout limit coincide, the byte wins (no abort).
  - The timer does not run in OUT; downstream stall is not a timeout.
- Output stability:
  - cmd_key and cmd_value may change while cmd_valid=0.
  - They never change while cmd_valid=1.
- Error pulses:
  - Each err_* output is high for exactly one cycle per event.
  - Error pulses are independent of each other and of cmd_valid.
- Bytes are never reordered or reused across frames.

Test Plan:
- Refer frame: bytes 03,12,34,56,78 with 10-cycle gaps, cmd_ready=1 → one cycle later cmd_valid=1, cmd_op=3, cmd_key=0x12345678, cmd_value=0; accepted the same cycle, then back to IDLE.
- Issue frame with backpressure:
  - Stimulus: bytes 01,00,00,00,2A,00,00,01,F4; cmd_ready=0 for 20 cycles.
  - Response: cmd_valid held with cmd_op=1, key=0x0000002A, value=0x000001F4, all stable throughout.
  - A byte 55 sent during the stall → err_drop pulse, outputs unchanged.
  - Raising cmd_ready → cmd_valid clears on the next edge.
- Bad opcode: byte 07 then a valid create frame 00,AA,BB,CC,DD,00,00,00,64 → err_opcode pulses once; the frame is then output as op=0, key=0xAABBCCDD, value=100.
- Timeout, with TIMEOUT_CYCLES=50:
  - Stimulus: bytes 02,11,22, then idle for 60 cycles, then transfer frame 02,01,02,03,04,00,00,00,05.
  - Response: err_timeout pulses 50 cycles after byte 22; the next frame is output as op=2, key=0x01020304, value=5, with no residue from the aborted bytes.
- Timeout boundary: a byte arriving exactly when the timer reaches the limit → no err_timeout, frame continues normally.
- Reset mid-operation:
  - rst=1 during the 3rd key byte → all outputs 0, state IDLE; a following full refer frame 03,00,00,00,09 outputs key=9.
  - rst=1 while cmd_valid=1 → cmd_valid=0 on the next edge.

Source files
------------

// File: rtl/cmd_frame_if.sv
// Byte-stream input and framed command output of the UART command parser.
// "master" is the assembler side; "slave" is the byte source / command consumer side.
interface cmd_frame_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_key;
    logic [31:0] cmd_value;
    logic        err_opcode;
    logic        err_timeout;
    logic        err_drop;

    modport master (
        input  byte_in, byte_valid, cmd_ready,
        output cmd_valid, cmd_op, cmd_key, cmd_value,
        output err_opcode, err_timeout, err_drop
    );

    modport slave (
        output byte_in, byte_valid, cmd_ready,
        input  cmd_valid, cmd_op, cmd_key, cmd_value,
        input  err_opcode, err_timeout, err_drop
    );
endinterface

// File: rtl/cmd_frame_assembler.sv
// Assembles opcode + 32-bit key + optional 32-bit value frames from a strobed
// byte stream, with an inter-byte timeout and valid/ready output hold.
module cmd_frame_assembler #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic clk,
    input  logic rst,
    cmd_frame_if.master bus
);

    typedef enum logic [1:0] {IDLE, KEY, VALUE, OUT} state_t;

    state_t           state_reg;
    logic [1:0]       byte_cnt_reg;
    logic [CNT_W-1:0] timer_reg;
    logic             cmd_valid_reg;
    logic [1:0]       cmd_op_reg;
    logic [31:0]      key_reg;
    logic [31:0]      value_reg;
    logic             err_opcode_reg;
    logic             err_timeout_reg;
    logic             err_drop_reg;
    logic             timer_expired;

    // The limit is reached on the edge that would bring the idle count to
    // TIMEOUT_CYCLES; a byte in that same cycle takes precedence.
    assign timer_expired = (timer_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            byte_cnt_reg    <= 2'd0;
            timer_reg       <= '0;
            cmd_valid_reg   <= 1'b0;
            cmd_op_reg      <= 2'd0;
            key_reg         <= 32'd0;
            value_reg       <= 32'd0;
            err_opcode_reg  <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_drop_reg    <= 1'b0;
        end else begin
            err_opcode_reg  <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_drop_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.byte_valid) begin
                        if (bus.byte_in <= 8'd3) begin
                            cmd_op_reg   <= bus.byte_in[1:0];
                            key_reg      <= 32'd0;
                            value_reg    <= 32'd0;
                            byte_cnt_reg <= 2'd0;
                            timer_reg    <= '0;
                            state_reg    <= KEY;
                        end else begin
                            err_opcode_reg <= 1'b1;
                        end
                    end
                end
                KEY: begin
                    if (bus.byte_valid) begin
                        key_reg      <= {key_reg[23:0], bus.byte_in};
                        timer_reg    <= '0;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            byte_cnt_reg <= 2'd0;
                            if (cmd_op_reg == 2'd3) begin
                                value_reg     <= 32'd0;
                                cmd_valid_reg <= 1'b1;
                                state_reg     <= OUT;
                            end else begin
                                state_reg <= VALUE;
                            end
                        end
                    end else if (timer_expired) begin
                        err_timeout_reg <= 1'b1;
                        byte_cnt_reg    <= 2'd0;
                        timer_reg       <= '0;
                        state_reg       <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                VALUE: begin
                    if (bus.byte_valid) begin
                        value_reg    <= {value_reg[23:0], bus.byte_in};
                        timer_reg    <= '0;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            byte_cnt_reg  <= 2'd0;
                            cmd_valid_reg <= 1'b1;
                            state_reg     <= OUT;
                        end
                    end else if (timer_expired) begin
                        err_timeout_reg <= 1'b1;
                        byte_cnt_reg    <= 2'd0;
                        timer_reg       <= '0;
                        state_reg       <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                OUT: begin
                    // Bytes are never buffered here, even on the accepting cycle.
                    if (bus.byte_valid) begin
                        err_drop_reg <= 1'b1;
                    end
                    if (bus.cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.cmd_valid   = cmd_valid_reg;
    assign bus.cmd_op      = cmd_op_reg;
    assign bus.cmd_key     = key_reg;
    assign bus.cmd_value   = value_reg;
    assign bus.err_opcode  = err_opcode_reg;
    assign bus.err_timeout = err_timeout_reg;
    assign bus.err_drop    = err_drop_reg;

endmodule

// File: tb/tb_cmd_frame_assembler.sv
// Bench for cmd_frame_assembler: directed frames with literal expectations plus
// randomized traffic, all checked every cycle against a byte-list frame model.
module tb_cmd_frame_assembler;

    localparam int TO = 50;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    cmd_frame_if bus();

    cmd_frame_assembler #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: the bytes collected so far, idle cycles since the last one,
    // and the frame being offered downstream.
    logic [7:0]  q[$];
    int          idle_cnt = 0;
    bit          pend = 0;
    logic [1:0]  m_op;
    logic [31:0] m_key;
    logic [31:0] m_val;
    bit          e_op, e_to, e_drop, e_zero;
    bit          live = 0;

    initial begin
        forever begin
            @(posedge clk);
            e_op = 0; e_to = 0; e_drop = 0; e_zero = 0;
            if (rst) begin
                q.delete();
                pend     = 0;
                idle_cnt = 0;
                e_zero   = 1;
            end else if (pend) begin
                if (bus.byte_valid) e_drop = 1;
                if (bus.cmd_ready) begin
                    pend = 0;
                    $display("frame accepted op=%0d key=%08h value=%08h", m_op, m_key, m_val);
                end
            end else if (q.size() == 0) begin
                if (bus.byte_valid) begin
                    if (bus.byte_in > 8'd3) e_op = 1;
                    else begin
                        q.push_back(bus.byte_in);
                        idle_cnt = 0;
                    end
                end
            end else if (bus.byte_valid) begin
                q.push_back(bus.byte_in);
                idle_cnt = 0;
                if (q.size() == ((q[0] == 8'd3) ? 5 : 9)) begin
                    pend  = 1;
                    m_op  = q[0][1:0];
                    m_key = {q[1], q[2], q[3], q[4]};
                    m_val = (q.size() == 9) ? {q[5], q[6], q[7], q[8]} : 32'd0;
                    q.delete();
                end
            end else begin
                idle_cnt++;
                if (idle_cnt == TO) begin
                    e_to = 1;
                    q.delete();
                end
            end
            live = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                chk("cmd_valid", {31'd0, bus.cmd_valid}, {31'd0, pend});
                chk("err_opcode", {31'd0, bus.err_opcode}, {31'd0, e_op});
                chk("err_timeout", {31'd0, bus.err_timeout}, {31'd0, e_to});
                chk("err_drop", {31'd0, bus.err_drop}, {31'd0, e_drop});
                if (pend) begin
                    chk("cmd_op", {30'd0, bus.cmd_op}, {30'd0, m_op});
                    chk("cmd_key", bus.cmd_key, m_key);
                    chk("cmd_value", bus.cmd_value, m_val);
                end
                if (e_zero) begin
                    chk("rst_op", {30'd0, bus.cmd_op}, 32'd0);
                    chk("rst_key", bus.cmd_key, 32'd0);
                    chk("rst_value", bus.cmd_value, 32'd0);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] b, input logic r);
        bus.byte_valid = v;
        bus.byte_in    = b;
        bus.cmd_ready  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, r);
    endtask

    task automatic send(input logic [7:0] b, input int gap, input logic r);
        idle_n(gap, r);
        step(1'b1, b, r);
    endtask

    // Sends the n low bytes of f, most significant first.
    task automatic send_frame(input logic [71:0] f, input int n, input int gap, input logic r);
        for (int i = 0; i < n; i++) send(f[8*(n-1-i) +: 8], gap, r);
    endtask

    task automatic chk_frame(input string name, input logic [1:0] op,
                             input logic [31:0] key, input logic [31:0] val);
        chk({name, "_valid"}, {31'd0, bus.cmd_valid}, 32'd1);
        chk({name, "_op"}, {30'd0, bus.cmd_op}, {30'd0, op});
        chk({name, "_key"}, bus.cmd_key, key);
        chk({name, "_value"}, bus.cmd_value, val);
    endtask

    initial begin
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        bus.cmd_ready  = 1'b0;
        idle_n(2, 1'b0);
        chk("reset_valid", {31'd0, bus.cmd_valid}, 32'd0);
        chk("reset_key", bus.cmd_key, 32'd0);
        rst = 1'b0;

        // Refer frame, accepted immediately
        send_frame(72'h0312345678, 5, 10, 1'b1);
        chk_frame("refer", 2'd3, 32'h12345678, 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("refer_release", {31'd0, bus.cmd_valid}, 32'd0);

        // Issue frame held by backpressure, with a dropped byte mid-stall
        send_frame(72'h010000002A000001F4, 9, 2, 1'b0);
        chk_frame("issue", 2'd1, 32'h0000002A, 32'h000001F4);
        idle_n(5, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        chk("drop_pulse", {31'd0, bus.err_drop}, 32'd1);
        idle_n(14, 1'b0);
        chk_frame("issue_held", 2'd1, 32'h0000002A, 32'h000001F4);
        step(1'b0, 8'h00, 1'b1);
        chk("issue_release", {31'd0, bus.cmd_valid}, 32'd0);

        // Bad opcode followed by a create frame
        send(8'h07, 3, 1'b1);
        chk("bad_opcode", {31'd0, bus.err_opcode}, 32'd1);
        send_frame(72'h00AABBCCDD00000064, 9, 1, 1'b0);
        chk_frame("create", 2'd0, 32'hAABBCCDD, 32'd100);
        step(1'b0, 8'h00, 1'b1);

        // Timeout after 50 idle cycles, then a clean transfer frame
        send_frame(72'h021122, 3, 1, 1'b1);
        idle_n(TO - 1, 1'b1);
        chk("timeout_early", {31'd0, bus.err_timeout}, 32'd0);
        idle_n(1, 1'b1);
        chk("timeout_pulse", {31'd0, bus.err_timeout}, 32'd1);
        idle_n(10, 1'b1);
        send_frame(72'h020102030400000005, 9, 1, 1'b0);
        chk_frame("transfer", 2'd2, 32'h01020304, 32'd5);
        step(1'b0, 8'h00, 1'b1);

        // Every byte lands exactly at the limit: no abort
        send_frame(72'h0300000077, 5, TO - 1, 1'b0);
        chk_frame("boundary", 2'd3, 32'h00000077, 32'd0);
        step(1'b0, 8'h00, 1'b1);

        // Reset during the 3rd key byte
        send_frame(72'h035A6B, 3, 1, 1'b1);
        rst = 1'b1;
        step(1'b1, 8'h7C, 1'b1);
        rst = 1'b0;
        chk("midrst_key", bus.cmd_key, 32'd0);
        chk("midrst_op", {30'd0, bus.cmd_op}, 32'd0);
        send_frame(72'h0300000009, 5, 1, 1'b0);
        chk_frame("after_rst", 2'd3, 32'h00000009, 32'd0);

        // Reset while a frame is pending
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk("rst_pending", {31'd0, bus.cmd_valid}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                idle_n($urandom_range(TO - 5, TO + 5), 1'($urandom_range(0, 1)));
            end else begin
                rst = ($urandom_range(0, 499) == 0);
                step(1'($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)));
                rst = 1'b0;
            end
        end
        idle_n(2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
